mtsc_query_engine: RTL and testbench
====================================

// Module: mtsc_query_engine
// PURPOSE
//   Next-generation slot-timed query engine: NUM_CH independent Collatz query lanes sharing one session/slot timer.
//   TTI length is programmable at run time and latched on start; each lane reports step count, overflow and a
//   one-cycle end pulse. Sits under the test harness as the DUT driven by the multi-channel scenario driver.
// PARAMETERS
//   NUM_CH          4       number of query lanes
//   BW_QUERY_DATA   8       query value width per lane
//   BW_STEP         16      per-lane step counter width (saturates at all-ones)
//   BW_SESSION      32      session counter width
//   BW_CLOCK_COUNT  32      slot clock counter / TTI length width
//   BW_SLOT_INDEX   32      slot index width
//   DEF_TTI_LEN     250000  TTI length in cycles, used when iTtiLen==0 at start
//   MAX_STEPS       1000    step limit (QUERY_TIMEOUT_EN only)
// PORTS
//   iClk           in   1                     clock
//   iRsn           in   1                     async active-low reset
//   iStart         in   1                     start session; latches iTtiLen
//   iTtiLen        in   BW_CLOCK_COUNT        TTI length in cycles; 0 selects DEF_TTI_LEN
//   oSlotTick      out  1                     slot boundary pulse
//   oSlotIndex     out  BW_SLOT_INDEX         current slot index
//   oSession       out  BW_SESSION            session count
//   iQueryDataEn   in   NUM_CH                per-lane load strobe
//   iQueryData     in   NUM_CH*BW_QUERY_DATA  per-lane load value, lane n at [n*BW+:BW]
//   oQueryData     out  NUM_CH*BW_QUERY_DATA  per-lane current value
//   oStepCount     out  NUM_CH*BW_STEP        per-lane steps taken
//   oQueryEnd      out  NUM_CH                per-lane 1-cycle completion pulse
//   oOverflow      out  NUM_CH                per-lane sticky overflow (cleared on next load)
//   oTimeout       out  NUM_CH                per-lane sticky timeout (QUERY_TIMEOUT_EN only; else tied 0)
//   oEnd           out  1                     level: session!=0 and no lane in RUN
// BEHAVIOUR
//   Reset: all counters, data, steps, flags, oQueryEnd, oSlotTick state = 0; TTI length reg = DEF_TTI_LEN; lanes IDLE.
//   Session: iStart -> session+1 (wraps). Slot: iStart -> count=0, index=0, ttiLen=(iTtiLen?iTtiLen:DEF_TTI_LEN).
//     Else session==0 -> count,index held 0. Else count==ttiLen-1 -> count=0, index+1 (wraps). Else count+1.
//   oSlotTick = iStart | (session!=0 & count==ttiLen-1), combinational; period exactly ttiLen cycles.
//   iTtiLen=1: tick every cycle after start. iTtiLen change without iStart: ignored.
//   Lane FSM IDLE/RUN/DONE, 1 step per cycle:
//     any state, En=1, value!=0 -> RUN, data=value, steps=0, flags cleared (abort/restart, no end pulse).
//     En=1, value==0 -> IDLE, data=0, oOverflow set, no end pulse.
//     RUN: data==1 -> DONE; even -> data>>1; odd -> data=3*data+1 computed in BW+2 bits;
//       upper 2 bits nonzero -> oOverflow=1, DONE, data holds pre-step value. Each real step: steps+1 (saturating).
//     DONE: oQueryEnd=1 this cycle, -> IDLE; data/steps/flags held until next load.
//   Latency: load value v at edge k, S steps to reach 1 -> oQueryEnd high in cycle after edge k+S+1.
//   En coincident with DONE: load wins, pulse suppressed. Lanes fully independent; no shared arbitration.
//   oEnd=0 while session==0.
// CONFIGURATION
//   QUERY_TIMEOUT_EN defined: RUN with steps==MAX_STEPS-1 taking a step -> oTimeout=1, DONE (pulse issued).
//   Undefined: no limit, steps saturate, oTimeout tied 0, MAX_STEPS unused.
// STRUCTURE
//   Package mtsc_query_pkg: lane state enum (IDLE/RUN/DONE), default widths, DEF_TTI_LEN.
//   Sub-module mtsc_collatz_lane: one lane FSM + step counter + flags; top = slot timer + generate loop of NUM_CH lanes.
// TESTING
//   Lane0 load 6 at edge k -> data 3,10,5,16,8,4,2,1; oQueryEnd[0] after edge k+9; steps=8; overflow=0.
//   Lane1 load 1 -> oQueryEnd[1] after edge k+1, steps=0; lane2 load 0 -> oOverflow[2]=1, no pulse.
//   Lane3 load 27 (BW=8) -> at 107 step 3*107+1=322 overflows: oOverflow[3]=1, end pulse, data=107.
//   iStart with iTtiLen=4 -> ticks at start cycle then every 4 cycles; oSlotIndex 0,1,2; iTtiLen=0 -> DEF_TTI_LEN period.
//   Reload lane0 with 7 mid-run -> no pulse for old query, steps restart; reset asserted mid-run -> all outputs 0.
//   QUERY_TIMEOUT_EN, MAX_STEPS=5, load 27 -> oTimeout=1, steps=5, end pulse.

Source files
------------

// File: rtl/mtsc_query_pkg.sv
// Shared types and default sizing for the slot-timed Collatz query engine.
// Lane state encoding plus the default widths and TTI length used by the top.
package mtsc_query_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } laneState_t;

   localparam int NUM_CH_DEF         = 4;
   localparam int BW_QUERY_DATA_DEF  = 8;
   localparam int BW_STEP_DEF        = 16;
   localparam int BW_SESSION_DEF     = 32;
   localparam int BW_CLOCK_COUNT_DEF = 32;
   localparam int BW_SLOT_INDEX_DEF  = 32;
   localparam int DEF_TTI_LEN        = 250000;
   localparam int MAX_STEPS_DEF      = 1000;

endpackage

// File: rtl/mtsc_query_engine_if.sv
// Per-lane query bus of the engine: load strobes/values in, lane status out.
// Lane n occupies slice [n*BW +: BW] of every flattened vector.
interface mtsc_query_engine_if #(
   parameter int NUM_CH        = mtsc_query_pkg::NUM_CH_DEF,
   parameter int BW_QUERY_DATA = mtsc_query_pkg::BW_QUERY_DATA_DEF,
   parameter int BW_STEP       = mtsc_query_pkg::BW_STEP_DEF
);
   logic [NUM_CH-1:0]               iQueryDataEn;
   logic [NUM_CH*BW_QUERY_DATA-1:0] iQueryData;
   logic [NUM_CH*BW_QUERY_DATA-1:0] oQueryData;
   logic [NUM_CH*BW_STEP-1:0]       oStepCount;
   logic [NUM_CH-1:0]               oQueryEnd;
   logic [NUM_CH-1:0]               oOverflow;
   logic [NUM_CH-1:0]               oTimeout;

   modport master (
      output iQueryDataEn, iQueryData,
      input  oQueryData, oStepCount, oQueryEnd, oOverflow, oTimeout
   );

   modport slave (
      input  iQueryDataEn, iQueryData,
      output oQueryData, oStepCount, oQueryEnd, oOverflow, oTimeout
   );
endinterface

// File: rtl/mtsc_collatz_lane.sv
// One Collatz query lane: IDLE/RUN/DONE FSM, saturating step counter, sticky flags.
// Optional step limit enabled by QUERY_TIMEOUT_EN.
module mtsc_collatz_lane import mtsc_query_pkg::*; #(
   parameter int BW      = BW_QUERY_DATA_DEF,
   parameter int BW_STEP = BW_STEP_DEF
`ifdef QUERY_TIMEOUT_EN
   , parameter int MAX_STEPS = MAX_STEPS_DEF
`endif
) (
   input  logic               iClk,
   input  logic               iRsn,
   input  logic               iEn,
   input  logic [BW-1:0]      iValue,
   output logic [BW-1:0]      oData,
   output logic [BW_STEP-1:0] oSteps,
   output logic               oQueryEnd,
   output logic               oOverflow,
   output logic               oTimeout,
   output logic               oRun
);
   localparam logic [BW-1:0]      DATA_ONE = BW'(1);
   localparam logic [BW_STEP-1:0] STEP_ONE = BW_STEP'(1);

   laneState_t         state;
   logic [BW+1:0]      triple;
   logic [BW_STEP-1:0] stepsInc;

   // 3x+1 with two guard bits; any guard bit set means the result will not fit
   assign triple   = {1'b0, oData, 1'b0} + {2'b00, oData} + {{(BW+1){1'b0}}, 1'b1};
   assign stepsInc = (&oSteps) ? oSteps : oSteps + STEP_ONE;
   assign oRun     = (state == RUN);

`ifdef QUERY_TIMEOUT_EN
   localparam logic [BW_STEP-1:0] STEP_LIMIT = BW_STEP'(MAX_STEPS - 1);
   logic timeoutQ;
   assign oTimeout = timeoutQ;
`else
   assign oTimeout = 1'b0;
`endif

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state     <= IDLE;
         oData     <= '0;
         oSteps    <= '0;
         oQueryEnd <= 1'b0;
         oOverflow <= 1'b0;
`ifdef QUERY_TIMEOUT_EN
         timeoutQ  <= 1'b0;
`endif
      end else begin
         oQueryEnd <= 1'b0;
         if (iEn) begin
            // a load always wins, aborting any query in flight without a pulse
            oData     <= iValue;
            oSteps    <= '0;
            oOverflow <= (iValue == '0);
            state     <= (iValue == '0) ? IDLE : RUN;
`ifdef QUERY_TIMEOUT_EN
            timeoutQ  <= 1'b0;
`endif
         end else begin
            case (state)
               RUN: begin
                  if (oData == DATA_ONE) begin
                     state     <= DONE;
                     oQueryEnd <= 1'b1;
                  end else if (oData[0] && (|triple[BW+1:BW])) begin
                     oOverflow <= 1'b1;
                     state     <= DONE;
                     oQueryEnd <= 1'b1;
                  end else begin
                     oData  <= oData[0] ? triple[BW-1:0] : (oData >> 1);
                     oSteps <= stepsInc;
`ifdef QUERY_TIMEOUT_EN
                     if (oSteps == STEP_LIMIT) begin
                        timeoutQ  <= 1'b1;
                        state     <= DONE;
                        oQueryEnd <= 1'b1;
                     end
`endif
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: rtl/mtsc_query_engine.sv
// Slot-timed query engine: shared session/slot timer plus NUM_CH Collatz lanes.
// Build option QUERY_TIMEOUT_EN adds a per-lane step limit of MAX_STEPS.
module mtsc_query_engine import mtsc_query_pkg::*; #(
   parameter int NUM_CH         = NUM_CH_DEF,
   parameter int BW_QUERY_DATA  = BW_QUERY_DATA_DEF,
   parameter int BW_STEP        = BW_STEP_DEF,
   parameter int BW_SESSION     = BW_SESSION_DEF,
   parameter int BW_CLOCK_COUNT = BW_CLOCK_COUNT_DEF,
   parameter int BW_SLOT_INDEX  = BW_SLOT_INDEX_DEF,
   parameter int DEF_TTI_LEN    = mtsc_query_pkg::DEF_TTI_LEN
`ifdef QUERY_TIMEOUT_EN
   , parameter int MAX_STEPS    = MAX_STEPS_DEF
`endif
) (
   input  logic                      iClk,
   input  logic                      iRsn,
   input  logic                      iStart,
   input  logic [BW_CLOCK_COUNT-1:0] iTtiLen,
   output logic                      oSlotTick,
   output logic [BW_SLOT_INDEX-1:0]  oSlotIndex,
   output logic [BW_SESSION-1:0]     oSession,
   mtsc_query_engine_if.slave        qIf,
   output logic                      oEnd
);
   localparam logic [BW_CLOCK_COUNT-1:0] TTI_DEF = BW_CLOCK_COUNT'(DEF_TTI_LEN);

   logic [BW_CLOCK_COUNT-1:0] slotCount;
   logic [BW_CLOCK_COUNT-1:0] ttiLen;
   logic                      slotLast;

   logic [NUM_CH-1:0][BW_QUERY_DATA-1:0] laneData;
   logic [NUM_CH-1:0][BW_STEP-1:0]       laneSteps;
   logic [NUM_CH-1:0]                    laneRun;

   assign slotLast  = (oSession != '0) && (slotCount == ttiLen - BW_CLOCK_COUNT'(1));
   assign oSlotTick = iStart | slotLast;
   assign oEnd      = (oSession != '0) && !(|laneRun);

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         oSession   <= '0;
         oSlotIndex <= '0;
         slotCount  <= '0;
         ttiLen     <= TTI_DEF;
      end else if (iStart) begin
         oSession   <= oSession + BW_SESSION'(1);
         oSlotIndex <= '0;
         slotCount  <= '0;
         ttiLen     <= (iTtiLen != '0) ? iTtiLen : TTI_DEF;
      end else if (slotLast) begin
         slotCount  <= '0;
         oSlotIndex <= oSlotIndex + BW_SLOT_INDEX'(1);
      end else if (oSession != '0) begin
         slotCount  <= slotCount + BW_CLOCK_COUNT'(1);
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : gLane
      mtsc_collatz_lane #(
         .BW        (BW_QUERY_DATA),
         .BW_STEP   (BW_STEP)
`ifdef QUERY_TIMEOUT_EN
         , .MAX_STEPS (MAX_STEPS)
`endif
      ) uLane (
         .iClk      (iClk),
         .iRsn      (iRsn),
         .iEn       (qIf.iQueryDataEn[n]),
         .iValue    (qIf.iQueryData[n*BW_QUERY_DATA +: BW_QUERY_DATA]),
         .oData     (laneData[n]),
         .oSteps    (laneSteps[n]),
         .oQueryEnd (qIf.oQueryEnd[n]),
         .oOverflow (qIf.oOverflow[n]),
         .oTimeout  (qIf.oTimeout[n]),
         .oRun      (laneRun[n])
      );
   end

   assign qIf.oQueryData = laneData;
   assign qIf.oStepCount = laneSteps;
endmodule

// File: tb/tb_mtsc_query_engine.sv
// Bench for mtsc_query_engine: trajectory-based lane model and elapsed-time slot model,
// compared every cycle, plus directed literal checks.
module tb_mtsc_query_engine;
   localparam int NUM_CH = 4;
   localparam int BW     = 8;
   localparam int BWS    = 16;
   localparam int DEFLEN = 12;
   localparam int MAXV   = (1 << BW) - 1;
`ifdef QUERY_TIMEOUT_EN
   localparam int MAXS   = 5;
`endif

   logic        iClk = 1'b0;
   logic        iRsn = 1'b0;
   logic        iStart = 1'b0;
   logic [31:0] iTtiLen = '0;
   logic        oSlotTick;
   logic [31:0] oSlotIndex;
   logic [31:0] oSession;
   logic        oEnd;

   mtsc_query_engine_if #(.NUM_CH(NUM_CH), .BW_QUERY_DATA(BW), .BW_STEP(BWS)) qIf ();

   mtsc_query_engine #(
      .NUM_CH(NUM_CH), .BW_QUERY_DATA(BW), .BW_STEP(BWS), .BW_SESSION(32),
      .BW_CLOCK_COUNT(32), .BW_SLOT_INDEX(32), .DEF_TTI_LEN(DEFLEN)
`ifdef QUERY_TIMEOUT_EN
      , .MAX_STEPS(MAXS)
`endif
   ) dut (
      .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iTtiLen(iTtiLen),
      .oSlotTick(oSlotTick), .oSlotIndex(oSlotIndex), .oSession(oSession),
      .qIf(qIf), .oEnd(oEnd)
   );

   always #5 iClk = ~iClk;

   int nChecks = 0;
   int nErrors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // ---------------- model ----------------
   int mSess = 0, mC = 0, mLen = DEFLEN;
   int mVals [NUM_CH][0:299];
   int mS [NUM_CH], mD [NUM_CH], mAge [NUM_CH];
   bit mLoaded [NUM_CH], mZero [NUM_CH], mOvf [NUM_CH], mTmo [NUM_CH];

   // Precompute the whole Collatz trajectory of v: mS real steps, outcome visible mD edges after load
   function automatic void loadModel(input int n, input int v);
      int x, i;
      bit fin;
      mLoaded[n] = 1; mAge[n] = 0; mOvf[n] = 0; mTmo[n] = 0;
      mZero[n] = (v == 0); mVals[n][0] = v; mS[n] = 0; mD[n] = 1;
      if (v == 0) return;
      x = v; i = 0; fin = 0;
      while (!fin && i < 290) begin
         if (x == 1) begin
            mS[n] = i; mD[n] = i + 1; fin = 1;
         end else if ((x % 2) == 1 && 3 * x + 1 > MAXV) begin
            mOvf[n] = 1; mS[n] = i; mD[n] = i + 1; fin = 1;
         end else begin
            x = ((x % 2) == 1) ? 3 * x + 1 : x / 2;
            i++;
            mVals[n][i] = x;
`ifdef QUERY_TIMEOUT_EN
            if (i == MAXS) begin
               mS[n] = i; mD[n] = i; mTmo[n] = 1; fin = 1;
            end
`endif
         end
      end
   endfunction

   initial
      for (int n = 0; n < NUM_CH; n++) begin
         mLoaded[n] = 0; mZero[n] = 0; mOvf[n] = 0; mTmo[n] = 0;
         mS[n] = 0; mD[n] = 0; mAge[n] = 0;
      end

   always @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         mSess = 0; mC = 0; mLen = DEFLEN;
         for (int n = 0; n < NUM_CH; n++) mLoaded[n] = 0;
      end else begin
         if (iStart) begin
            mSess++; mC = 0;
            mLen = (iTtiLen != 0) ? int'(iTtiLen) : DEFLEN;
         end else if (mSess != 0) mC++;
         for (int n = 0; n < NUM_CH; n++)
            if (qIf.iQueryDataEn[n]) loadModel(n, int'(qIf.iQueryData[n*BW +: BW]));
            else if (mLoaded[n] && mAge[n] < 1000000) mAge[n]++;
      end
   end

   always @(negedge iClk) begin
      int e, ix, eData, eSteps;
      bit eEnd, eOvf, eTmo, eRun, anyRun;
      chk("session", oSession, mSess);
      chk("slotIndex", oSlotIndex, (mSess != 0) ? mC / mLen : 0);
      chk("slotTick", oSlotTick, iStart || (mSess != 0 && (mC % mLen) == mLen - 1));
      anyRun = 0;
      for (int n = 0; n < NUM_CH; n++) begin
         eData = 0; eSteps = 0; eEnd = 0; eOvf = 0; eTmo = 0; eRun = 0;
         if (mLoaded[n] && mZero[n]) eOvf = 1;
         else if (mLoaded[n]) begin
            e = mAge[n];
            ix = (e < mS[n]) ? e : mS[n];
            eData = mVals[n][ix]; eSteps = ix;
            eEnd = (e == mD[n]); eRun = (e < mD[n]);
            eOvf = mOvf[n] && (e >= mD[n]);
            eTmo = mTmo[n] && (e >= mD[n]);
         end
         anyRun |= eRun;
         chk($sformatf("data%0d", n), qIf.oQueryData[n*BW +: BW], eData);
         chk($sformatf("steps%0d", n), qIf.oStepCount[n*BWS +: BWS], eSteps);
         chk($sformatf("queryEnd%0d", n), qIf.oQueryEnd[n], eEnd);
         chk($sformatf("overflow%0d", n), qIf.oOverflow[n], eOvf);
         chk($sformatf("timeout%0d", n), qIf.oTimeout[n], eTmo);
      end
      chk("end", oEnd, mSess != 0 && !anyRun);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge iClk);
      #2;
   endtask

   task automatic load(input int ch, input logic [7:0] v);
      qIf.iQueryDataEn[ch] = 1'b1;
      qIf.iQueryData[ch*BW +: BW] = v;
   endtask

   initial begin
      qIf.iQueryDataEn = '0;
      qIf.iQueryData   = '0;
      tick(2);
      chk("rst session", oSession, 0);
      chk("rst end", oEnd, 0);
      chk("rst data", qIf.oQueryData, 0);
      iRsn = 1'b1;
      tick(1);

      // slot timer, TTI=4; a later iTtiLen change without start is ignored
      iStart = 1'b1; iTtiLen = 32'd4;
      #1 chk("tick at start", oSlotTick, 1);
      tick(1);
      iStart = 1'b0; iTtiLen = 32'd9;
      #1 chk("index after start", oSlotIndex, 0);
      chk("session 1", oSession, 1);
      tick(3);
      chk("tick slot0 end", oSlotTick, 1);
      tick(1);
      chk("index 1", oSlotIndex, 1);
      tick(4);
      chk("index 2", oSlotIndex, 2);

      // four lanes loaded together at edge k
      load(0, 8'd6); load(1, 8'd1); load(2, 8'd0); load(3, 8'd27);
      tick(1);
      qIf.iQueryDataEn = '0;
      chk("lane2 zero overflow", qIf.oOverflow[2], 1);
      tick(1);
      chk("lane1 end k+1", qIf.oQueryEnd[1], 1);
      chk("lane1 steps", qIf.oStepCount[1*BWS +: BWS], 0);
      tick(4);
`ifdef QUERY_TIMEOUT_EN
      chk("lane3 timeout", qIf.oTimeout[3], 1);
      chk("lane3 timeout end", qIf.oQueryEnd[3], 1);
      chk("lane3 timeout steps", qIf.oStepCount[3*BWS +: BWS], 5);
`endif
      tick(4);
`ifndef QUERY_TIMEOUT_EN
      chk("lane0 end k+9", qIf.oQueryEnd[0], 1);
      chk("lane0 steps 8", qIf.oStepCount[0 +: BWS], 8);
      chk("lane0 data 1", qIf.oQueryData[0 +: BW], 1);
`endif
      tick(3);
`ifndef QUERY_TIMEOUT_EN
      chk("lane3 end k+12", qIf.oQueryEnd[3], 1);
      chk("lane3 overflow", qIf.oOverflow[3], 1);
      chk("lane3 data 107", qIf.oQueryData[3*BW +: BW], 107);
      chk("lane3 steps 11", qIf.oStepCount[3*BWS +: BWS], 11);
`endif
      tick(2);

      // reload lane0 mid-run: old query aborted, steps restart
      load(0, 8'd9);
      tick(1);
      qIf.iQueryDataEn = '0;
      tick(3);
      load(0, 8'd7);
      tick(1);
      qIf.iQueryDataEn = '0;
      tick(2);
      chk("reload data 11", qIf.oQueryData[0 +: BW], 11);
      chk("reload steps 2", qIf.oStepCount[0 +: BWS], 2);
      tick(20);

      // load coincident with DONE transition suppresses the pulse
      load(1, 8'd2);
      tick(1);
      qIf.iQueryDataEn = '0;
      tick(1);
      load(1, 8'd4);
      tick(1);
      qIf.iQueryDataEn = '0;
      chk("suppressed end", qIf.oQueryEnd[1], 0);
      chk("reload wins data", qIf.oQueryData[1*BW +: BW], 4);
      tick(5);

      // iTtiLen=0 selects default period
      iStart = 1'b1; iTtiLen = 32'd0;
      tick(1);
      iStart = 1'b0;
      tick(DEFLEN - 1);
      chk("default tick", oSlotTick, 1);
      chk("default index 0", oSlotIndex, 0);
      tick(1);
      chk("default index 1", oSlotIndex, 1);

      // iTtiLen=1: tick every cycle
      iStart = 1'b1; iTtiLen = 32'd1;
      tick(1);
      iStart = 1'b0;
      tick(3);
      chk("len1 tick", oSlotTick, 1);
      chk("len1 index", oSlotIndex, 3);

      // reset mid-run
      load(3, 8'd27);
      tick(1);
      qIf.iQueryDataEn = '0;
      tick(3);
      iRsn = 1'b0;
      #1;
      chk("midrst data", qIf.oQueryData, 0);
      chk("midrst steps", qIf.oStepCount, 0);
      chk("midrst session", oSession, 0);
      chk("midrst tick", oSlotTick, 0);
      tick(1);
      iRsn = 1'b1;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule
